// File: rtl/defog_mode_ctrl.sv
// Defog display-path mode controller: debounces the board switches, decodes a
// stage select and applies it only at frame starts, blanking while the pipeline refills.
module defog_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_FRAMES   = 2,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic [2:0]  sw,
    input  logic        i_vsync,
    output logic [1:0]  o_sel,
    output logic        o_blank,
    output logic        o_switching,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned SCNT_W = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    logic [2:0]        swMeta_q;
    logic [2:0]        swSync_q;
    logic [2:0]        cand_q;
    logic [2:0]        cand_d;
    logic [2:0]        stable_q;
    logic [2:0]        stable_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        reqSel;

    logic              vsPrev_q;
    logic              vsArm_q;
    logic              frameStart;
    logic [15:0]       frameCnt_q;

    state_t            state_q;
    logic [SCNT_W-1:0] scnt_q;
    logic [1:0]        sel_q;
    logic              blank_q;
    logic              switching_q;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (swSync_q != cand_q) begin
            cand_d = swSync_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            swMeta_q <= '0;
            swSync_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            swMeta_q <= sw;
            swSync_q <= swMeta_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Only a single clean one-hot switch pattern selects a stage; anything else is bypass.
    always_comb begin
        case (stable_q)
            3'b001:  reqSel = 2'd1;
            3'b010:  reqSel = 2'd2;
            3'b100:  reqSel = 2'd3;
            default: reqSel = 2'd0;
        endcase
    end

    // vsArm_q stays low until vsync has been seen low after reset, so a vsync
    // already high at reset release is not mistaken for a fresh frame start.
    assign frameStart = i_vsync & ~vsPrev_q & vsArm_q;

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vsPrev_q   <= 1'b0;
            vsArm_q    <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            vsPrev_q <= i_vsync;
            if (!i_vsync) begin
                vsArm_q <= 1'b1;
            end
            if (frameStart) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end
        end
    end

    // Select changes land on a frame start; blanking then spans whole frames.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state_q     <= RUN;
            scnt_q      <= '0;
            sel_q       <= 2'd0;
            blank_q     <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (reqSel != sel_q) begin
                        state_q     <= PEND;
                        switching_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (reqSel == sel_q) begin
                        state_q     <= RUN;
                        switching_q <= 1'b0;
                    end else if (frameStart) begin
                        sel_q <= reqSel;
                        if (SETTLE_FRAMES == 0) begin
                            state_q     <= RUN;
                            switching_q <= 1'b0;
                        end else begin
                            blank_q <= 1'b1;
                            scnt_q  <= SCNT_INIT;
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (frameStart) begin
                        if (scnt_q == SCNT_W'(1)) begin
                            blank_q     <= 1'b0;
                            state_q     <= RUN;
                            switching_q <= 1'b0;
                        end else begin
                            scnt_q <= scnt_q - SCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= RUN;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_sel       = sel_q;
    assign o_blank     = blank_q;
    assign o_switching = switching_q;
    assign o_frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_defog_mode_ctrl.sv
// Scoreboard bench for defog_mode_ctrl: expected output transitions are queued
// as switches are driven and checked as the DUT outputs change.
module tb_defog_mode_ctrl;

    typedef struct packed {
        logic [1:0] sel;
        logic       blank;
        logic       switching;
        logic       atFs;
    } expEvent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        resetB;
    logic        vsync;
    logic [2:0]  sw;
    logic [2:0]  swB;

    logic [1:0]  o_selA;
    logic        o_blankA;
    logic        o_switchingA;
    logic [15:0] o_frame_cntA;
    logic [1:0]  o_selB;
    logic        o_blankB;
    logic        o_switchingB;
    logic [15:0] o_frame_cntB;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fsAt = -1;
    logic [15:0] benchFrames = 16'd0;
    logic        vsPrev = 1'b0;
    logic        vsArm = 1'b0;

    expEvent_t   qA[$];
    expEvent_t   qB[$];
    expEvent_t   evA;
    expEvent_t   evB;
    logic [3:0]  prevA = 4'd0;
    logic [3:0]  prevB = 4'd0;
    logic        monA = 1'b0;
    logic        monB = 1'b0;
    logic        blankSeenB = 1'b0;
    int          lat;

    always #5 clk = ~clk;

    defog_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_FRAMES  (2),
        .CNT_W          (3)
    ) dutA (
        .pixelclk   (clk),
        .reset      (reset),
        .sw         (sw),
        .i_vsync    (vsync),
        .o_sel      (o_selA),
        .o_blank    (o_blankA),
        .o_switching(o_switchingA),
        .o_frame_cnt(o_frame_cntA)
    );

    defog_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_FRAMES  (0),
        .CNT_W          (3)
    ) dutB (
        .pixelclk   (clk),
        .reset      (resetB),
        .sw         (swB),
        .i_vsync    (vsync),
        .o_sel      (o_selB),
        .o_blank    (o_blankB),
        .o_switching(o_switchingB),
        .o_frame_cnt(o_frame_cntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic expectA(input logic [1:0] s, input logic b, input logic w, input logic f);
        qA.push_back({s, b, w, f});
    endtask

    task automatic expectB(input logic [1:0] s, input logic b, input logic w, input logic f);
        qB.push_back({s, b, w, f});
    endtask

    task automatic applyStimulus(input logic [2:0] value);
        @(negedge clk);
        sw = value;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput({tag, ".drain"}, 32'(qA.size() + qB.size()), 32'd0);
    endtask

    task automatic waitSwitchingA(output int n);
        n = 0;
        while (!o_switchingA && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Frame-start reference: a vsync rise counts only once vsync was seen low after reset.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        vsPrev <= vsync;
        if (reset) begin
            benchFrames <= 16'd0;
            vsArm       <= 1'b0;
        end else begin
            if (!vsync) vsArm <= 1'b1;
            if (vsync && !vsPrev && vsArm) begin
                benchFrames <= benchFrames + 16'd1;
                fsAt        <= cyc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (monA && {o_selA, o_blankA, o_switchingA} != prevA) begin
            if (qA.size() == 0) begin
                checkOutput("A.unexpectedEvent", 32'(qA.size()), 32'd1);
            end else begin
                evA = qA.pop_front();
                checkOutput("A.evSel", 32'(o_selA), 32'(evA.sel));
                checkOutput("A.evBlank", 32'(o_blankA), 32'(evA.blank));
                checkOutput("A.evSwitching", 32'(o_switchingA), 32'(evA.switching));
                checkOutput("A.evFrameCnt", 32'(o_frame_cntA), 32'(benchFrames));
                if (evA.atFs) checkOutput("A.evAtFrameStart", 32'(fsAt), 32'(cyc));
            end
        end
        prevA <= {o_selA, o_blankA, o_switchingA};
    end

    always @(negedge clk) begin
        if (monB && {o_selB, o_blankB, o_switchingB} != prevB) begin
            if (qB.size() == 0) begin
                checkOutput("B.unexpectedEvent", 32'(qB.size()), 32'd1);
            end else begin
                evB = qB.pop_front();
                checkOutput("B.evSel", 32'(o_selB), 32'(evB.sel));
                checkOutput("B.evBlank", 32'(o_blankB), 32'(evB.blank));
                checkOutput("B.evSwitching", 32'(o_switchingB), 32'(evB.switching));
                if (evB.atFs) checkOutput("B.evAtFrameStart", 32'(fsAt), 32'(cyc));
            end
        end
        if (monB && o_blankB) blankSeenB <= 1'b1;
        prevB <= {o_selB, o_blankB, o_switchingB};
    end

    // Vsync: 4-cycle pulse every 100 cycles, changing on the falling edge.
    initial begin
        int ph;
        ph    = 0;
        vsync = 1'b0;
        forever begin
            @(negedge clk);
            vsync = (ph >= 50 && ph < 54);
            ph    = (ph + 1) % 100;
        end
    end

    initial begin
        int n;
        reset  = 1'b1;
        resetB = 1'b1;
        sw     = 3'b000;
        swB    = 3'b000;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        monA  = 1'b1;
        @(negedge clk);
        checkOutput("T1.sel", 32'(o_selA), 32'd0);
        checkOutput("T1.blank", 32'(o_blankA), 32'd0);
        checkOutput("T1.switching", 32'(o_switchingA), 32'd0);
        checkOutput("T1.frameCntReset", 32'(o_frame_cntA), 32'd0);
        n = 0;
        while (benchFrames != 16'd3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("T1.frameCnt3", 32'(o_frame_cntA), 32'd3);

        applyStimulus(3'b001);
        repeat (3) @(negedge clk);
        sw = 3'b000;
        repeat (40) @(negedge clk);
        checkOutput("T3.glitchSel", 32'(o_selA), 32'd0);
        checkOutput("T3.glitchSwitching", 32'(o_switchingA), 32'd0);

        applyStimulus(3'b011);
        repeat (40) @(negedge clk);
        checkOutput("T4.multiSel", 32'(o_selA), 32'd0);
        checkOutput("T4.multiSwitching", 32'(o_switchingA), 32'd0);

        expectA(2'd0, 1'b0, 1'b1, 1'b0);
        expectA(2'd1, 1'b1, 1'b1, 1'b1);
        expectA(2'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b001);
        waitSwitchingA(lat);
        $display("[TB] T2 switch-to-switching latency %0d cycles", lat);
        checkOutput("T2.latencyInRange", 32'(lat >= 6 && lat <= 9), 32'd1);
        waitDrain("T2", 600);

        expectA(2'd1, 1'b0, 1'b1, 1'b0);
        expectA(2'd3, 1'b1, 1'b1, 1'b1);
        expectA(2'd3, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b100);
        waitDrain("T4.to3", 600);
        expectA(2'd3, 1'b0, 1'b1, 1'b0);
        expectA(2'd0, 1'b1, 1'b1, 1'b1);
        expectA(2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b110);
        waitDrain("T4.to0", 600);
        checkOutput("T4.selBypass", 32'(o_selA), 32'd0);

        expectA(2'd0, 1'b0, 1'b1, 1'b0);
        expectA(2'd2, 1'b1, 1'b1, 1'b1);
        applyStimulus(3'b010);
        waitDrain("T5.to2", 600);
        expectA(2'd2, 1'b0, 1'b0, 1'b1);
        expectA(2'd2, 1'b0, 1'b1, 1'b0);
        expectA(2'd3, 1'b1, 1'b1, 1'b1);
        expectA(2'd3, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b100);
        repeat (30) @(negedge clk);
        checkOutput("T5.settleHoldSel", 32'(o_selA), 32'd2);
        checkOutput("T5.settleBlank", 32'(o_blankA), 32'd1);
        waitDrain("T5.to3", 800);

        expectA(2'd3, 1'b0, 1'b1, 1'b0);
        expectA(2'd2, 1'b1, 1'b1, 1'b1);
        applyStimulus(3'b010);
        waitDrain("T6.to2", 600);
        checkOutput("T6.blankBeforeReset", 32'(o_blankA), 32'd1);
        expectA(2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("T6.resetSel", 32'(o_selA), 32'd0);
        checkOutput("T6.resetBlank", 32'(o_blankA), 32'd0);
        checkOutput("T6.resetSwitching", 32'(o_switchingA), 32'd0);
        checkOutput("T6.resetFrameCnt", 32'(o_frame_cntA), 32'd0);
        expectA(2'd0, 1'b0, 1'b1, 1'b0);
        expectA(2'd2, 1'b1, 1'b1, 1'b1);
        expectA(2'd2, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        waitSwitchingA(lat);
        $display("[TB] T6 reset-release-to-switching latency %0d cycles", lat);
        checkOutput("T6.latencyInRange", 32'(lat >= 6 && lat <= 9), 32'd1);
        waitDrain("T6.reaccept", 600);

        @(negedge clk);
        resetB = 1'b0;
        monB   = 1'b1;
        expectB(2'd0, 1'b0, 1'b1, 1'b0);
        expectB(2'd1, 1'b0, 1'b0, 1'b1);
        swB = 3'b001;
        waitDrain("T7", 600);
        checkOutput("T7.sel", 32'(o_selB), 32'd1);
        checkOutput("T7.blankNeverSeen", 32'(blankSeenB), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
